// File: rtl/game2048_pkg.sv
// Shared types for the 2048 game controller: board/tile types, move encodings,
// controller states and the single-line slide/merge function.
package game2048_pkg;
  localparam int SCORE_W = 20;

  typedef logic [11:0] tile_t;
  typedef tile_t [3:0] line_t;
  typedef tile_t [3:0][3:0] board_t;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  typedef enum logic [3:0] {
    IDLE, SPAWN_A, SPAWN_B, WAIT_MOVE, APPLY, SPAWN, CHECK, WON, LOST
  } ctrl_state_t;

  typedef struct packed {
    line_t              line;
    logic [SCORE_W-1:0] pts;
  } line_res_t;

  // Slides one line toward index 0; each tile merges at most once per move.
  function automatic line_res_t merge_line(line_t line_i);
    tile_t [4:0] c;
    logic [2:0]  n;
    logic        skip;
    line_res_t   r;
    c    = '0;
    n    = '0;
    r    = '0;
    skip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (line_i[i] != '0) begin
        c[n] = line_i[i];
        n    = n + 3'd1;
      end
    end
    n = '0;
    // c[4] is always zero, so the c[i+1] look-ahead never matches a real tile
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (c[i] != '0) begin
        if (c[i] == c[i+1]) begin
          r.line[n[1:0]] = c[i] + c[i];
          r.pts          = r.pts + SCORE_W'(c[i]) + SCORE_W'(c[i]);
          skip           = 1'b1;
        end else begin
          r.line[n[1:0]] = c[i];
        end
        n = n + 3'd1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/game2048_if.sv
// Controller bus: keypad/debouncer side drives requests, renderer side reads
// the registered board, score and game status.
interface game2048_if;
  import game2048_pkg::*;

  logic               start;
  logic [3:0]         dir_req;
  logic               load_en;
  board_t             load_board;
  board_t             board;
  logic [SCORE_W-1:0] score;
  logic               ready;
  logic               move_invalid;
  logic               won;
  logic               lost;

  modport master (
    output start, dir_req, load_en, load_board,
    input  board, score, ready, move_invalid, won, lost
  );
  modport slave (
    input  start, dir_req, load_en, load_board,
    output board, score, ready, move_invalid, won, lost
  );
endinterface

// File: rtl/game2048_merge.sv
// Combinational move/merge datapath: applies one one-hot direction to the
// whole board and returns the new board plus points earned by merges.
module game2048_merge
  import game2048_pkg::*;
(
  input  board_t             board_i,
  input  logic [3:0]         dir_i,
  output board_t             board_o,
  output logic [SCORE_W-1:0] pts_o
);
  always_comb begin
    line_t     ln;
    line_res_t res;
    logic      dir_ok;
    board_o = board_i;
    pts_o   = '0;
    ln      = '0;
    res     = '0;
    dir_ok  = (dir_i == DIR_UP) || (dir_i == DIR_DOWN) ||
              (dir_i == DIR_LEFT) || (dir_i == DIR_RIGHT);
    // Each line is gathered so that index 0 is the wall tiles slide toward.
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 4; i++) begin
        case (dir_i)
          DIR_UP:    ln[i] = board_i[i][l];
          DIR_DOWN:  ln[i] = board_i[3-i][l];
          DIR_RIGHT: ln[i] = board_i[l][3-i];
          default:   ln[i] = board_i[l][i];
        endcase
      end
      res = merge_line(ln);
      for (int i = 0; i < 4; i++) begin
        case (dir_i)
          DIR_UP:    board_o[i][l]   = res.line[i];
          DIR_DOWN:  board_o[3-i][l] = res.line[i];
          DIR_LEFT:  board_o[l][i]   = res.line[i];
          DIR_RIGHT: board_o[l][3-i] = res.line[i];
          default:   ;
        endcase
      end
      if (dir_ok) pts_o = pts_o + res.pts;
    end
  end
endmodule

// File: rtl/game2048_tile_spawner.sv
// Places one 2/4 tile into a pseudo-randomly chosen empty cell and reports
// the empty-cell count used by the loss test.
module tile_spawner
  import game2048_pkg::*;
(
  input  board_t      board_i,
  input  logic [11:0] lfsr_i,
  output board_t      board_o,
  output logic [4:0]  empty_o
);
  always_comb begin
    logic [4:0] cnt;
    logic [4:0] seen;
    logic [7:0] div;
    logic [7:0] pick;
    tile_t      val;
    cnt = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (board_i[r][c] == '0) cnt = cnt + 5'd1;
    empty_o = cnt;
    div     = (cnt == '0) ? 8'd1 : {3'b0, cnt};
    pick    = lfsr_i[7:0] % div;
    val     = (lfsr_i[11:8] == 4'd0) ? tile_t'(4) : tile_t'(2);
    board_o = board_i;
    seen    = '0;
    // A full board never matches, leaving it unchanged.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (board_i[r][c] == '0) begin
          if (seen == pick[4:0]) board_o[r][c] = val;
          seen = seen + 5'd1;
        end
  end
endmodule

// File: rtl/game2048_controller.sv
// Sequencing FSM for one 2048 game: start/spawn, move apply and commit,
// random tile spawn, win/lose detection.
module game2048_controller
  import game2048_pkg::*;
#(
  parameter int          WIN_VALUE = 2048,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic       clk,
  input logic       rst_n,
  game2048_if.slave bus
);
  ctrl_state_t        state_q, state_d;
  board_t             board_q, board_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [3:0]         dir_q, dir_d;

  board_t             merged, spawned;
  logic [SCORE_W-1:0] pts;
  logic [4:0]         empty_cnt;
  logic [SCORE_W:0]   score_sum;
  logic               has_pair, has_win, changed;

  game2048_merge u_merge (
    .board_i (board_q),
    .dir_i   (dir_q),
    .board_o (merged),
    .pts_o   (pts)
  );

  tile_spawner u_spawn (
    .board_i (board_q),
    .lfsr_i  (lfsr_q[11:0]),
    .board_o (spawned),
    .empty_o (empty_cnt)
  );

  assign score_sum = {1'b0, score_q} + {1'b0, pts};
  assign changed   = (merged != board_q);

  always_comb begin
    has_pair = 1'b0;
    has_win  = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (board_q[r][c] == board_q[r][c+1]) has_pair = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        if (board_q[r][c] == board_q[r+1][c]) has_pair = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (board_q[r][c] >= tile_t'(WIN_VALUE)) has_win = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    score_d = score_q;
    dir_d   = dir_q;
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (bus.start) begin
      board_d = '0;
      score_d = '0;
      state_d = SPAWN_A;
    end else begin
      case (state_q)
        IDLE: if (bus.load_en) begin
          board_d = bus.load_board;
          state_d = CHECK;
        end
        WAIT_MOVE: begin
          if (bus.load_en) begin
            board_d = bus.load_board;
            state_d = CHECK;
          end else if ($onehot(bus.dir_req)) begin
            dir_d   = bus.dir_req;
            state_d = APPLY;
          end
        end
        APPLY: begin
          if (changed) begin
            board_d = merged;
            score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            state_d = SPAWN;
          end else begin
            state_d = WAIT_MOVE;
          end
        end
        SPAWN_A: begin
          board_d = spawned;
          state_d = SPAWN_B;
        end
        SPAWN_B, SPAWN: begin
          board_d = spawned;
          state_d = CHECK;
        end
        CHECK: begin
          if (has_win)                           state_d = WON;
          else if (empty_cnt == '0 && !has_pair) state_d = LOST;
          else                                   state_d = WAIT_MOVE;
        end
        WON, LOST: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      board_q <= '0;
      score_q <= '0;
      lfsr_q  <= LFSR_SEED;
      dir_q   <= '0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      score_q <= score_d;
      lfsr_q  <= lfsr_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.board        = board_q;
  assign bus.score        = score_q;
  assign bus.ready        = (state_q == WAIT_MOVE);
  assign bus.won          = (state_q == WON);
  assign bus.lost         = (state_q == LOST);
  // A pending start discards the APPLY result, so no pulse in that case.
  assign bus.move_invalid = (state_q == APPLY) && !changed && !bus.start;
endmodule

// File: tb/tb_game2048_controller.sv
// Directed bench for game2048_controller: scoreboarded move results and an
// independent spawn/LFSR reference for exact board prediction.
module tb_game2048_controller;
  import game2048_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string              tag;
    board_t             board;
    logic [SCORE_W-1:0] score;
  } exp_t;
  exp_t sbq[$];

  game2048_if bus();

  game2048_controller #(.WIN_VALUE(2048), .LFSR_SEED(SEED)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  function automatic board_t m_spawn(board_t b, logic [15:0] l);
    int zr[$];
    int zc[$];
    int k;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (b[r][c] == 0) begin
          zr.push_back(r);
          zc.push_back(c);
        end
    if (zr.size() == 0) return b;
    k = int'(l[7:0]) % zr.size();
    b[zr[k]][zc[k]] = (l[11:8] == 4'd0) ? 12'd4 : 12'd2;
    return b;
  endfunction

  function automatic int n_tiles(board_t b);
    int n = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (b[r][c] != 0) n++;
    return n;
  endfunction

  function automatic bit tiles_2_or_4(board_t b);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (b[r][c] != 0 && b[r][c] != 2 && b[r][c] != 4) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 1'b1, 1'b0);
      return;
    end
    e = sbq.pop_front();
    chk({e.tag, "_board"}, bus.board, e.board);
    chk({e.tag, "_score"}, bus.score, e.score);
  endtask

  task automatic sb_push(input string tag, input board_t b, input logic [SCORE_W-1:0] s);
    exp_t e;
    e.tag   = tag;
    e.board = b;
    e.score = s;
    sbq.push_back(e);
  endtask

  task automatic new_game(output board_t e);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_clear_board", bus.board, '0);
    chk("start_clear_score", bus.score, 20'd0);
    e = m_spawn('0, m_lfsr);
    tick();
    e = m_spawn(e, m_lfsr);
    tick();
    chk("start_spawn_board", bus.board, e);
    tick();
    chk("start_ready", bus.ready, 1'b1);
  endtask

  task automatic load(input board_t b);
    bus.load_board = b;
    bus.load_en    = 1'b1;
    tick();
    bus.load_en    = 1'b0;
    tick();
  endtask

  // Returns the board expected after the post-move spawn; caller checks N+4.
  task automatic move_valid(input string tag, input logic [3:0] d, input board_t exp_b,
                            input logic [SCORE_W-1:0] exp_s, output board_t e);
    sb_push(tag, exp_b, exp_s);
    bus.dir_req = d;
    tick();
    bus.dir_req = 4'b0;
    chk({tag, "_apply_ready"}, bus.ready, 1'b0);
    chk({tag, "_apply_inv"}, bus.move_invalid, 1'b0);
    tick();
    sb_check();
    e = m_spawn(exp_b, m_lfsr);
    tick();
    chk({tag, "_spawn_board"}, bus.board, e);
    chk({tag, "_spawn_ready"}, bus.ready, 1'b0);
    tick();
  endtask

  initial begin
    board_t b, e;
    bus.start      = 1'b0;
    bus.dir_req    = 4'b0;
    bus.load_en    = 1'b0;
    bus.load_board = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_board", bus.board, '0);
    chk("rst_score", bus.score, 20'd0);
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_won", bus.won, 1'b0);
    chk("rst_lost", bus.lost, 1'b0);
    chk("rst_inv", bus.move_invalid, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();

    // New game: exactly two 2/4 tiles, ready after three cycles.
    new_game(e);
    chk("ng_ntiles", n_tiles(bus.board), 2);
    chk("ng_tile_vals", tiles_2_or_4(bus.board), 1'b1);
    chk("ng_won", bus.won, 1'b0);
    chk("ng_lost", bus.lost, 1'b0);

    // Valid LEFT move: [2,2,4,0] -> [4,4,0,0], one merge of 2+2.
    b = '0;
    b[0][0] = 12'd2; b[0][1] = 12'd2; b[0][2] = 12'd4;
    load(b);
    chk("ld1_ready", bus.ready, 1'b1);
    chk("ld1_board", bus.board, b);
    b = '0;
    b[0][0] = 12'd4; b[0][1] = 12'd4;
    move_valid("mv_left", DIR_LEFT, b, 20'd4, e);
    chk("mv_left_ready_n4", bus.ready, 1'b1);
    chk("mv_left_ntiles", n_tiles(bus.board), 3);

    // Invalid move: nothing slides or merges.
    b = '0;
    b[0][0] = 12'd2; b[0][1] = 12'd4; b[0][2] = 12'd8; b[0][3] = 12'd16;
    load(b);
    sb_push("mv_inv", b, 20'd4);
    bus.dir_req = DIR_LEFT;
    tick();
    bus.dir_req = 4'b0;
    chk("mv_inv_pulse", bus.move_invalid, 1'b1);
    chk("mv_inv_ready_n1", bus.ready, 1'b0);
    tick();
    sb_check();
    chk("mv_inv_pulse_end", bus.move_invalid, 1'b0);
    chk("mv_inv_ready_n2", bus.ready, 1'b1);

    // RIGHT and UP on a column/row mix exercise the other line orientations.
    b = '0;
    b[1][0] = 12'd2; b[1][1] = 12'd2; b[1][2] = 12'd2; b[3][3] = 12'd8;
    load(b);
    b = '0;
    b[1][2] = 12'd2; b[1][3] = 12'd4; b[3][3] = 12'd8;
    move_valid("mv_right", DIR_RIGHT, b, 20'd8, e);
    chk("mv_right_ready", bus.ready, 1'b1);
    b = '0;
    b[0][1] = 12'd4; b[2][1] = 12'd4; b[3][1] = 12'd8; b[3][2] = 12'd2;
    load(b);
    b = '0;
    b[0][1] = 12'd8; b[1][1] = 12'd8; b[0][2] = 12'd2;
    move_valid("mv_up", DIR_UP, b, 20'd16, e);
    chk("mv_up_ready", bus.ready, 1'b1);

    // Win: 1024+1024 reaches 2048, then the game is frozen until start.
    b = '0;
    b[0][0] = 12'd1024; b[0][1] = 12'd1024;
    load(b);
    b = '0;
    b[0][0] = 12'd2048;
    move_valid("mv_win", DIR_LEFT, b, 20'd2064, e);
    chk("win_flag", bus.won, 1'b1);
    chk("win_ready", bus.ready, 1'b0);
    bus.dir_req = DIR_RIGHT;
    tick();
    bus.dir_req = 4'b0;
    bus.load_board = '0;
    bus.load_en = 1'b1;
    tick();
    bus.load_en = 1'b0;
    tick();
    chk("win_hold_board", bus.board, e);
    chk("win_hold_score", bus.score, 20'd2064);
    chk("win_hold_flag", bus.won, 1'b1);
    new_game(e);
    chk("win_restart_won", bus.won, 1'b0);

    // Loss: full checkerboard of 2/4 has no merges left.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = ((r + c) % 2 == 1) ? 12'd4 : 12'd2;
    load(b);
    chk("lost_flag", bus.lost, 1'b1);
    chk("lost_ready", bus.ready, 1'b0);
    bus.dir_req = DIR_DOWN;
    tick();
    bus.dir_req = 4'b0;
    tick();
    chk("lost_hold_board", bus.board, b);
    chk("lost_hold_flag", bus.lost, 1'b1);

    // Multi-bit request in WAIT_MOVE is ignored.
    new_game(e);
    chk("lost_restart", bus.lost, 1'b0);
    bus.dir_req = 4'b0011;
    tick();
    chk("multi_ready", bus.ready, 1'b1);
    chk("multi_inv", bus.move_invalid, 1'b0);
    tick();
    bus.dir_req = 4'b0;
    chk("multi_board", bus.board, e);

    // Reset during APPLY: immediate clear, and the LFSR restarts from its seed.
    b = '0;
    b[2][0] = 12'd2; b[2][1] = 12'd2;
    load(b);
    bus.dir_req = DIR_LEFT;
    tick();
    bus.dir_req = 4'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_apply_board", bus.board, '0);
    chk("rst_apply_score", bus.score, 20'd0);
    chk("rst_apply_ready", bus.ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    new_game(e);
    chk("rst_seed_ntiles", n_tiles(bus.board), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
